fifo_rd_stream_adapter: RTL and testbench
=========================================

// Module: fifo_rd_stream_adapter
// PURPOSE
// - Read-side consumer of the async FIFO: drains the FIFO through its Empty/R_inc/R_Data read port.
// - Presents the words as a valid/ready stream to logic in the read clock domain.
// - 2-entry output buffer: full throughput, and no combinational path from Out_Ready to R_inc.
// - Counts delivered words.
// PARAMETERS
// DATA_WIDTH  8   width of FIFO data words and of Out_Data
// CNT_WIDTH   16  width of the delivered-word counter Rd_Count
// PORTS
// R_CLK      in   1           read-domain clock; all state updates on rising edge
// R_rst_n    in   1           reset, synchronous, active-low
// Empty      in   1           FIFO empty flag (already synchronous to R_CLK)
// R_Data     in   DATA_WIDTH  FIFO head word; combinational, valid while Empty=0
// R_inc      out  1           FIFO pop; one word is removed at each R_CLK edge where R_inc=1
// En         in   1           1 = allow pops from FIFO; 0 = stop popping, buffer still drains
// Out_Valid  out  1           Out_Data holds a valid word
// Out_Data   out  DATA_WIDTH  stream data, oldest buffered word
// Out_Ready  in   1           downstream accepts; transfer when Out_Valid & Out_Ready at an edge
// Rd_Count   out  CNT_WIDTH   number of stream transfers since reset, modulo 2^CNT_WIDTH
// BEHAVIOUR
// - Storage: head reg D0, skid reg D1, occupancy state OCC in {ZERO, ONE, TWO}.
// - Reset (R_rst_n=0 at an edge):
//   - OCC=ZERO; D0=D1=0; Rd_Count=0.
//   - Out_Valid=0 and Out_Data=0 after the edge.
//   - R_inc is forced 0 combinationally while R_rst_n=0.
// - R_inc = R_rst_n & En & ~Empty & (OCC!=TWO). Depends only on registered state, En and Empty.
// - push = R_inc; pop = Out_Valid & Out_Ready.
// - Out_Valid = (OCC!=ZERO), registered.
// - Out_Data = D0, registered.
// - Transitions and data moves per edge:
//   - ZERO push          -> ONE, D0<=R_Data
//   - ONE  push & ~pop   -> TWO, D1<=R_Data
//   - ONE  push & pop    -> ONE, D0<=R_Data
//   - ONE  ~push & pop   -> ZERO
//   - TWO  pop           -> ONE, D0<=D1   (push is impossible in TWO)
//   - no push, no pop    -> hold everything
// - Latency: a word popped at edge k is on Out_Data with Out_Valid=1 after edge k.
// - Steady streaming, Out_Ready=1: 1 word/cycle.
// - Ordering is strict FIFO. No word is dropped or duplicated.
// - Stall: while Out_Valid=1 and Out_Ready=0, Out_Data and Out_Valid hold stable.
//   - At most 2 further words are popped, then R_inc=0 until a pop frees a slot.
// - Empty=1 or En=0: R_inc=0; buffered words continue to be offered and drained.
// - Rd_Count += 1 on every pop. Wraps 2^CNT_WIDTH-1 -> 0 with no flag.
// - Reset mid-operation: buffered words are discarded. FIFO contents are untouched (no R_inc).
// TESTING
// - Reset: hold R_rst_n=0 for 2 cycles, Empty=0 -> R_inc=0 throughout.
//   - After release: Out_Valid=0, Out_Data=0, Rd_Count=0.
// - Stream: FIFO model holds 0x11,0x12,0x13,0x14; Out_Ready=1, En=1.
//   - R_inc high 4 consecutive cycles.
//   - Out_Data = 0x11..0x14 on consecutive cycles, each one cycle after its pop.
//   - Rd_Count=4.
// - Backpressure: same data, Out_Ready=0.
//   - Exactly 2 pops, then R_inc=0; Out_Data holds 0x11.
//   - Release Out_Ready -> 0x11,0x12,0x13,0x14 in order; Rd_Count=4.
// - Flow control: Empty=1, or En=0 with 1 word buffered.
//   - R_inc never asserted.
//   - The buffered word drains on Out_Ready=1, then Out_Valid=0.
// - Wrap: CNT_WIDTH=4, stream 17 words with Out_Ready=1 -> Rd_Count=1.
// - Mid-op reset: OCC=TWO (Out_Ready=0), assert R_rst_n=0 for 1 edge.
//   - R_inc=0 during reset; Out_Valid=0 after the edge.
//   - Next word streamed out is the FIFO head at release.

Source files
------------

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side consumer of an async FIFO.
// Drains words through the Empty/R_inc/R_Data port and offers them as a
// valid/ready stream through a 2-entry buffer (head + skid). Because the skid
// slot absorbs one extra word, R_inc never depends on Out_Ready, yet a
// continuous stream still moves one word per cycle. Delivered words are counted.
module fifo_rd_stream_adapter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  R_CLK,
    input  logic                  R_rst_n,
    input  logic                  Empty,
    input  logic [DATA_WIDTH-1:0] R_Data,
    output logic                  R_inc,
    input  logic                  En,
    output logic                  Out_Valid,
    output logic [DATA_WIDTH-1:0] Out_Data,
    input  logic                  Out_Ready,
    output logic [CNT_WIDTH-1:0]  Rd_Count
);

    typedef enum logic [1:0] {
        OccZero,
        OccOne,
        OccTwo
    } occ_e;

    occ_e                  occ_q, occ_d;
    logic [DATA_WIDTH-1:0] d0_q, d0_d;
    logic [DATA_WIDTH-1:0] d1_q, d1_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  push;
    logic                  pop;

    // Pop the FIFO only while a buffer slot is free; uses registered state only.
    always_comb begin
        R_inc = R_rst_n & En & ~Empty & (occ_q != OccTwo);
        push  = R_inc;
        pop   = Out_Valid & Out_Ready;
    end

    // Outputs come straight from registers.
    always_comb begin
        Out_Valid = (occ_q != OccZero);
        Out_Data  = d0_q;
        Rd_Count  = cnt_q;
    end

    // Next occupancy, buffer data moves and transfer count.
    always_comb begin
        occ_d = occ_q;
        d0_d  = d0_q;
        d1_d  = d1_q;
        cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
        case (occ_q)
            OccZero: begin
                if (push) begin
                    occ_d = OccOne;
                    d0_d  = R_Data;
                end
            end
            OccOne: begin
                if (push && !pop) begin
                    occ_d = OccTwo;
                    d1_d  = R_Data;
                end else if (push && pop) begin
                    d0_d = R_Data;
                end else if (pop) begin
                    occ_d = OccZero;
                end
            end
            OccTwo: begin
                // push cannot happen here: R_inc is blocked while full
                if (pop) begin
                    occ_d = OccOne;
                    d0_d  = d1_q;
                end
            end
            default: begin
                occ_d = OccZero;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset discards the buffer.
    always_ff @(posedge R_CLK) begin
        if (!R_rst_n) begin
            occ_q <= OccZero;
            d0_q  <= '0;
            d1_q  <= '0;
            cnt_q <= '0;
        end else begin
            occ_q <= occ_d;
            d0_q  <= d0_d;
            d1_q  <= d1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: a per-cycle vector table covers
// reset, streaming, backpressure, flow control and mid-operation reset; a
// hand-written sequence covers counter wrap on a narrow-counter instance.
module tb_fifo_rd_stream_adapter;

    logic        clk;
    logic        rst_n;
    logic        emp_force;
    logic        empty;
    logic [7:0]  r_data;
    logic        r_inc;
    logic        r_inc4;
    logic        en;
    logic        out_ready;
    logic        out_valid;
    logic        out_valid4;
    logic [7:0]  out_data;
    logic [7:0]  out_data4;
    logic [15:0] rd_count;
    logic [3:0]  rd_count4;

    logic [7:0]  mem [0:63];
    logic [5:0]  rd_ptr;
    logic [5:0]  wr_ptr;

    int checks;
    int errors;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        rdy;
        logic        emp;
        logic        e_rinc;
        logic        e_valid;
        logic [7:0]  e_data;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [0:27];

    fifo_rd_stream_adapter #(
        .DATA_WIDTH(8),
        .CNT_WIDTH (16)
    ) dut (
        .R_CLK    (clk),
        .R_rst_n  (rst_n),
        .Empty    (empty),
        .R_Data   (r_data),
        .R_inc    (r_inc),
        .En       (en),
        .Out_Valid(out_valid),
        .Out_Data (out_data),
        .Out_Ready(out_ready),
        .Rd_Count (rd_count)
    );

    fifo_rd_stream_adapter #(
        .DATA_WIDTH(8),
        .CNT_WIDTH (4)
    ) dut4 (
        .R_CLK    (clk),
        .R_rst_n  (rst_n),
        .Empty    (empty),
        .R_Data   (r_data),
        .R_inc    (r_inc4),
        .En       (en),
        .Out_Valid(out_valid4),
        .Out_Data (out_data4),
        .Out_Ready(out_ready),
        .Rd_Count (rd_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: head word is combinational, pop on edges where R_inc=1.
    assign empty  = emp_force | (rd_ptr == wr_ptr);
    assign r_data = mem[rd_ptr];

    always @(posedge clk) begin
        if (r_inc) rd_ptr <= rd_ptr + 6'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic e, input logic rdy, input logic emp,
                                input logic rinc, input logic v, input logic [7:0] d,
                                input logic [15:0] c);
        vec_t r;
        r.rst     = rst;
        r.en      = e;
        r.rdy     = rdy;
        r.emp     = emp;
        r.e_rinc  = rinc;
        r.e_valid = v;
        r.e_data  = d;
        r.e_cnt   = c;
        return r;
    endfunction

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        emp_force = 1'b0;
        rd_ptr    = 6'd0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        // FIFO preload: stream, backpressure, en=0 word, mid-op reset words
        mem[0] = 8'h11; mem[1] = 8'h12; mem[2]  = 8'h13; mem[3]  = 8'h14;
        mem[4] = 8'h11; mem[5] = 8'h12; mem[6]  = 8'h13; mem[7]  = 8'h14;
        mem[8] = 8'h55; mem[9] = 8'h66; mem[10] = 8'h77; mem[11] = 8'h88;
        wr_ptr = 6'd12;

        //              rst   en    rdy   emp   rinc  vld   data   cnt
        // reset held 2 cycles with data available
        vecs[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
        vecs[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
        // streaming 0x11..0x14 with Out_Ready=1
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 16'd0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 16'd1);
        vecs[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h13, 16'd2);
        vecs[5]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h14, 16'd3);
        vecs[6]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h14, 16'd4);
        // backpressure: two pops then stall, then release
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 16'd0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 16'd0);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 16'd0);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 16'd0);
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 16'd1);
        vecs[13] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h13, 16'd2);
        vecs[14] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h14, 16'd3);
        vecs[15] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h14, 16'd4);
        // Empty=1: no pops at all
        vecs[16] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        vecs[17] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        vecs[18] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        // En=0 with one word buffered: it still drains
        vecs[19] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 16'd0);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 16'd0);
        vecs[21] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 16'd1);
        vecs[22] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 16'd1);
        // fill to two entries, reset for one edge, resume from FIFO head
        vecs[23] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 16'd1);
        vecs[24] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 16'd1);
        vecs[25] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
        vecs[26] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h88, 16'd0);
        vecs[27] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h88, 16'd1);

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            rst_n     = ~vecs[i].rst;
            en        = vecs[i].en;
            out_ready = vecs[i].rdy;
            emp_force = vecs[i].emp;
            #1;
            check($sformatf("vec%0d r_inc", i), {31'b0, r_inc}, {31'b0, vecs[i].e_rinc});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("vec%0d out_data", i), {24'b0, out_data}, {24'b0, vecs[i].e_data});
            check($sformatf("vec%0d rd_count", i), {16'b0, rd_count}, {16'b0, vecs[i].e_cnt});
        end

        // Counter wrap: 17 words streamed, 4-bit counter ends at 1.
        for (int k = 0; k < 17; k++) mem[12 + k] = 8'hA0 + 8'(k);
        @(negedge clk);
        rst_n     = 1'b0;
        emp_force = 1'b1;
        @(negedge clk);
        rst_n     = 1'b1;
        emp_force = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        wr_ptr    = 6'd29;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk);
            #1;
            if (c <= 17) begin
                check($sformatf("wrap stream data c%0d", c), {24'b0, out_data},
                      {24'b0, 8'hA0 + 8'(c - 1)});
            end
            if (c == 17) begin
                check("wrap cnt4 at 16", {28'b0, rd_count4}, 32'd0);
                check("wrap cnt16 at 16", {16'b0, rd_count}, 32'd16);
            end
            if (c == 18) begin
                check("wrap cnt4 at 17", {28'b0, rd_count4}, 32'd1);
                check("wrap cnt16 at 17", {16'b0, rd_count}, 32'd17);
                check("wrap drained", {31'b0, out_valid}, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
